acc_dump: RTL and testbench

Integrate-and-dump accumulator for signed fixed-point samples. Sums a runtime-programmable number of valid input samples per frame and emits one full-precision result per frame, with saturation and an overflow flag. It sits directly upstream of `convert`, which requantizes the wide accumulator output, with the binary point unchanged at BIN_PT_IN, to the downstream format.

---
 rtl/acc_dump_pkg.sv | 9 +
 rtl/acc_dump_sat_add.sv | 21 ++
 rtl/acc_dump.sv | 105 ++++++++++
 tb/tb_acc_dump.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/acc_dump_pkg.sv
// Shared types for the integrate-and-dump accumulator.
package acc_dump_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/acc_dump_sat_add.sv
// Combinational signed saturating adder; clamps to the W-bit rails and flags the clamp.
module acc_dump_sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);

  localparam logic [W-1:0] POS_RAIL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_RAIL = {1'b1, {(W-1){1'b0}}};

  logic [W:0] s;

  // One guard bit: overflow iff guard and MSB disagree; the guard carries the true sign.
  assign s   = {a[W-1], a} + {b[W-1], b};
  assign ovf = s[W] ^ s[W-1];
  assign y   = ovf ? (s[W] ? NEG_RAIL : POS_RAIL) : s[W-1:0];

endmodule

// File: rtl/acc_dump.sv
// Integrate-and-dump accumulator: sums acc_len valid samples per frame, emits one
// saturated full-precision sum per frame with an overflow flag.
module acc_dump
  import acc_dump_pkg::*;
#(
  parameter int N_BITS_IN  = 8,
  parameter int BIN_PT_IN  = 7,
  parameter int N_BITS_ACC = 24,
  parameter int LEN_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync,
  input  logic [LEN_BITS-1:0]   acc_len,
  input  logic [N_BITS_IN-1:0]  din,
  input  logic                  din_vld,
  output logic [N_BITS_ACC-1:0] dout,
  output logic                  dout_vld,
  output logic                  ovf,
  output logic                  armed
);

  if (N_BITS_ACC < N_BITS_IN || BIN_PT_IN > N_BITS_IN) begin : g_bad_params
    $error("acc_dump: N_BITS_ACC must be >= N_BITS_IN and BIN_PT_IN <= N_BITS_IN");
  end

  state_t                state;
  logic [LEN_BITS-1:0]   len_q;
  logic [LEN_BITS-1:0]   cnt_q;
  logic [N_BITS_ACC-1:0] acc_q;
  logic                  flag_q;

  logic [LEN_BITS-1:0]   len_fix;
  logic [LEN_BITS-1:0]   eff_len;
  logic [LEN_BITS-1:0]   base_cnt;
  logic [LEN_BITS-1:0]   cnt_inc;
  logic [N_BITS_ACC-1:0] base_acc;
  logic [N_BITS_ACC-1:0] din_ext;
  logic [N_BITS_ACC-1:0] sum;
  logic                  base_flag;
  logic                  sum_ovf;
  logic                  active;
  logic                  take;
  logic                  last;

  // A sync restarts the frame this very cycle, so its sample sees a cleared frame.
  assign len_fix   = (acc_len == '0) ? LEN_BITS'(1) : acc_len;
  assign eff_len   = sync ? len_fix : len_q;
  assign base_cnt  = sync ? '0 : cnt_q;
  assign base_acc  = sync ? '0 : acc_q;
  assign base_flag = sync ? 1'b0 : flag_q;
  assign active    = sync || (state == ST_ACC);
  assign take      = active && din_vld;
  assign cnt_inc   = base_cnt + LEN_BITS'(1);
  assign last      = take && (cnt_inc == eff_len);
  assign din_ext   = N_BITS_ACC'($signed(din));

  acc_dump_sat_add #(.W(N_BITS_ACC)) u_sat_add (
    .a   (base_acc),
    .b   (din_ext),
    .y   (sum),
    .ovf (sum_ovf)
  );

  assign armed = (state == ST_ACC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      len_q    <= LEN_BITS'(1);
      cnt_q    <= '0;
      acc_q    <= '0;
      flag_q   <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      if (sync) state <= ST_ACC;
      if (active) begin
        if (last) begin
          // Dump and open the next frame with no gap; length re-latched here.
          dout     <= sum;
          dout_vld <= 1'b1;
          ovf      <= base_flag | sum_ovf;
          acc_q    <= '0;
          cnt_q    <= '0;
          flag_q   <= 1'b0;
          len_q    <= len_fix;
        end else if (take) begin
          acc_q  <= sum;
          cnt_q  <= cnt_inc;
          flag_q <= base_flag | sum_ovf;
          len_q  <= eff_len;
        end else begin
          acc_q  <= base_acc;
          cnt_q  <= base_cnt;
          flag_q <= base_flag;
          len_q  <= eff_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_dump.sv
// Bench for acc_dump: an 8-bit and a 6-bit accumulator share one stimulus stream and
// are compared against an integer reference model through expected queues.
module tb_acc_dump;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic [3:0] acc_len = '0;
  logic [3:0] din = '0;
  logic       din_vld = 1'b0;

  logic [7:0] dout8;
  logic       dout_vld8, ovf8, armed8;
  logic [5:0] dout6;
  logic       dout_vld6, ovf6, armed6;

  always #5 clk = ~clk;

  acc_dump #(.N_BITS_IN(4), .BIN_PT_IN(3), .N_BITS_ACC(8), .LEN_BITS(4)) u_dut8 (
    .clk(clk), .rst(rst), .sync(sync), .acc_len(acc_len), .din(din), .din_vld(din_vld),
    .dout(dout8), .dout_vld(dout_vld8), .ovf(ovf8), .armed(armed8)
  );

  acc_dump #(.N_BITS_IN(4), .BIN_PT_IN(3), .N_BITS_ACC(6), .LEN_BITS(4)) u_dut6 (
    .clk(clk), .rst(rst), .sync(sync), .acc_len(acc_len), .din(din), .din_vld(din_vld),
    .dout(dout6), .dout_vld(dout_vld6), .ovf(ovf6), .armed(armed6)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_q8[$];
  logic [6:0] exp_q6[$];

  // Reference model state
  bit         m_armed;
  int         m_len, m_cnt, m_acc8, m_acc6;
  bit         m_f8, m_f6;
  logic [7:0] m_dout8;
  logic [5:0] m_dout6;
  logic       m_ovf8, m_ovf6;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int sat(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_reset();
    m_armed = 0; m_len = 1; m_cnt = 0; m_acc8 = 0; m_acc6 = 0;
    m_f8 = 0; m_f6 = 0; m_dout8 = '0; m_dout6 = '0; m_ovf8 = 0; m_ovf6 = 0;
    exp_q8.delete();
    exp_q6.delete();
  endtask

  task automatic compare_outputs(input bit dump);
    logic [8:0] e8;
    logic [6:0] e6;
    check("dout_vld8", dout_vld8, dump);
    check("dout_vld6", dout_vld6, dump);
    check("armed8", armed8, m_armed);
    check("armed6", armed6, m_armed);
    if (dump) begin
      e8 = exp_q8.pop_front();
      e6 = exp_q6.pop_front();
      m_dout8 = e8[7:0]; m_ovf8 = e8[8];
      m_dout6 = e6[5:0]; m_ovf6 = e6[6];
    end
    check("dout8", dout8, m_dout8);
    check("ovf8", ovf8, m_ovf8);
    check("dout6", dout6, m_dout6);
    check("ovf6", ovf6, m_ovf6);
  endtask

  // Drive one cycle of stimulus, advance the model, then sample after the edge.
  task automatic drive(input logic s, input logic [3:0] len, input logic [3:0] d, input logic v);
    int ds, r8, r6, new_len;
    bit dump;
    sync = s; acc_len = len; din = d; din_vld = v;
    new_len = (len == 0) ? 1 : int'(len);
    dump = 0;
    if (s) begin
      m_armed = 1; m_len = new_len; m_cnt = 0;
      m_acc8 = 0; m_acc6 = 0; m_f8 = 0; m_f6 = 0;
    end
    if (m_armed && v) begin
      ds = int'($signed(d));
      r8 = m_acc8 + ds;
      r6 = m_acc6 + ds;
      if (r8 != sat(r8, 8)) m_f8 = 1;
      if (r6 != sat(r6, 6)) m_f6 = 1;
      m_acc8 = sat(r8, 8);
      m_acc6 = sat(r6, 6);
      m_cnt++;
      if (m_cnt == m_len) begin
        exp_q8.push_back({m_f8, 8'(m_acc8)});
        exp_q6.push_back({m_f6, 6'(m_acc6)});
        dump = 1;
        m_cnt = 0; m_acc8 = 0; m_acc6 = 0; m_f8 = 0; m_f6 = 0;
        m_len = new_len;
      end
    end
    @(posedge clk);
    #1;
    compare_outputs(dump);
  endtask

  task automatic do_reset();
    rst = 1'b1; sync = 0; din_vld = 0;
    @(posedge clk);
    #1;
    model_reset();
    compare_outputs(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // No sync: samples ignored
    for (int i = 0; i < 10; i++) drive(0, 4'd4, 4'b0010, 1);

    // Four 0.25 samples with gaps -> 1.0
    drive(1, 4'd4, 4'b0000, 0);
    drive(0, 4'd4, 4'b0010, 1);
    drive(0, 4'd4, 4'b0000, 0);
    drive(0, 4'd4, 4'b0010, 1);
    drive(0, 4'd4, 4'b0010, 1);
    drive(0, 4'd4, 4'b0000, 0);
    drive(0, 4'd4, 4'b0010, 1);
    drive(0, 4'd4, 4'b0000, 0);
    check("tp_quarter_dout", dout8, 8'h08);
    check("tp_quarter_ovf", ovf8, 1'b0);

    // Back-to-back frames of length 2
    drive(1, 4'd2, 4'b0000, 0);
    drive(0, 4'd2, 4'b0001, 1);
    drive(0, 4'd2, 4'b0011, 1);
    check("tp_b2b_first", dout8, 8'h04);
    drive(0, 4'd2, 4'b1111, 1);
    drive(0, 4'd2, 4'b1110, 1);
    check("tp_b2b_second", dout8, 8'hFD);

    // Saturation, both rails, then recovery
    drive(1, 4'd15, 4'b0000, 0);
    for (int i = 0; i < 15; i++) drive(0, 4'd15, 4'b0111, 1);
    check("tp_sat_pos_dout", dout6, 6'h1F);
    check("tp_sat_pos_ovf", ovf6, 1'b1);
    check("tp_nosat_dout8", dout8, 8'h69);
    for (int i = 0; i < 15; i++) drive(0, (i == 14) ? 4'd1 : 4'd15, 4'b1000, 1);
    check("tp_sat_neg_dout", dout6, 6'h20);
    check("tp_sat_neg_ovf", ovf6, 1'b1);
    drive(0, 4'd1, 4'b0001, 1);
    check("tp_recover_dout", dout6, 6'h01);
    check("tp_recover_ovf", ovf6, 1'b0);

    // Sync mid-frame restarts, sync-cycle sample counts as sample 1
    drive(1, 4'd4, 4'b0000, 0);
    drive(0, 4'd4, 4'b0001, 1);
    drive(0, 4'd4, 4'b0001, 1);
    drive(1, 4'd4, 4'b0010, 1);
    drive(0, 4'd4, 4'b0011, 1);
    drive(0, 4'd4, 4'b0001, 1);
    drive(0, 4'd4, 4'b0001, 1);
    check("tp_resync_dout", dout8, 8'h07);

    // Sync landing on what would have been the last sample
    drive(1, 4'd2, 4'b0000, 0);
    drive(0, 4'd2, 4'b0011, 1);
    drive(1, 4'd2, 4'b0001, 1);
    drive(0, 4'd2, 4'b0001, 1);
    check("tp_resync_last", dout8, 8'h02);

    // acc_len = 0 behaves as 1
    drive(1, 4'd0, 4'b0101, 1);
    drive(0, 4'd0, 4'b1001, 1);
    drive(0, 4'd0, 4'b0000, 0);
    drive(0, 4'd0, 4'b0110, 1);
    check("tp_len0_dout", dout8, 8'h06);

    // Reset mid-frame, then samples without sync are ignored
    drive(1, 4'd4, 4'b0011, 1);
    drive(0, 4'd4, 4'b0011, 1);
    do_reset();
    for (int i = 0; i < 6; i++) drive(0, 4'd1, 4'b0111, 1);

    // Random traffic
    drive(1, 4'd3, 4'b0000, 0);
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));

    check("sb8_drained", exp_q8.size(), 0);
    check("sb6_drained", exp_q6.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
